sync_filter_bank: RTL and testbench

Multi-channel clock-domain-crossing input conditioner. It is the parametrised successor to the team's single-bit two-flop gated synchronizer. Each of WIDTH asynchronous inputs passes through:
- a STAGES-deep synchronizer,
- a consecutive-cycle glitch filter,
- a per-channel synchronous enable gate,
- an output register with single-cycle rise/fall event pulses.

It sits at the boundary between external/asynchronous status pins and d_clk-domain control logic.

---
 rtl/sync_filter_bank.sv | 133 +++++++++++++
 tb/tb_sync_filter_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_filter_bank.sv
// sync_filter_bank
// -----------------------------------------------------------------------------
// Multi-channel input conditioner for asynchronous status pins entering the
// d_clk domain. Each of WIDTH channels is independent and passes through:
//   1. a STAGES-deep flop synchronizer,
//   2. an optional consecutive-cycle glitch filter,
//   3. a synchronous per-channel enable gate,
//   4. an output register that also produces one-cycle rise/fall pulses.
//
// Build option:
//   SYNC_FILTER_BANK_GLITCH_FILTER_EN
//     defined   : the filtered level only follows the synchronized input after
//                 FILT_CNT consecutive mismatching cycles. Capture-to-output
//                 latency is STAGES+FILT_CNT edges.
//     undefined : no filter or counters are built. The filtered level is the
//                 last synchronizer stage, and FILT_CNT has no effect.
//
// Parameters:
//   WIDTH    - number of channels (>= 1)
//   STAGES   - synchronizer depth (>= 2)
//   FILT_CNT - mismatching cycles needed to change the filtered level (>= 1)
//
// Ports:
//   d_clk      - clock, all state changes on the rising edge
//   d_rst_n    - asynchronous active-low reset, clears all state
//   sig_in     - asynchronous channel inputs
//   sig_en     - per-channel enable, synchronous to d_clk, not filtered
//   sig_out    - registered filtered and gated level
//   rise_pulse - one-cycle pulse when sig_out[i] goes 0 -> 1
//   fall_pulse - one-cycle pulse when sig_out[i] goes 1 -> 0
//   any_change - OR of all rise and fall pulses
// -----------------------------------------------------------------------------
module sync_filter_bank #(
    parameter int WIDTH    = 4,
    parameter int STAGES   = 2,
    parameter int FILT_CNT = 3
) (
    input  logic             d_clk,
    input  logic             d_rst_n,
    input  logic [WIDTH-1:0] sig_in,
    input  logic [WIDTH-1:0] sig_en,
    output logic [WIDTH-1:0] sig_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    // Reject configurations the structure below cannot build.
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_filter_bank: WIDTH must be at least 1");
    end
    if (STAGES < 2) begin : g_bad_stages
        $error("sync_filter_bank: STAGES must be at least 2");
    end
    if (FILT_CNT < 1) begin : g_bad_filt_cnt
        $error("sync_filter_bank: FILT_CNT must be at least 1");
    end

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             sync_lvl;
    logic [WIDTH-1:0]             filt_lvl;
    logic [WIDTH-1:0]             gate_lvl;

    // Plain shift chain: nothing may sit between stages, otherwise the
    // metastability settling time of each flop is eaten into.
    always_ff @(posedge d_clk or negedge d_rst_n) begin
        if (!d_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig_in};
        end
    end

    assign sync_lvl = sync_q[STAGES-1];

`ifdef SYNC_FILTER_BANK_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILT_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

    logic [WIDTH-1:0] filt_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];

    // The counter measures how long the synchronized level has disagreed with
    // the filtered level. Any agreement restarts the run, so a mismatch run
    // shorter than FILT_CNT cycles never reaches the filtered level. The
    // counter is cleared when the level is taken, so it stops at CNT_LAST.
    always_ff @(posedge d_clk or negedge d_rst_n) begin
        if (!d_rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_lvl[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    filt_q[i] <= sync_lvl[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign filt_lvl = filt_q;
`else
    assign filt_lvl = sync_lvl;
`endif

    // The enable is already in the d_clk domain, so it gates after the filter
    // and takes effect at the very next edge.
    assign gate_lvl = filt_lvl & sig_en;

    // Edge pulses compare the new gated level with the registered one, so a
    // channel can never raise both pulses in the same cycle.
    always_ff @(posedge d_clk or negedge d_rst_n) begin
        if (!d_rst_n) begin
            sig_out    <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            sig_out    <= gate_lvl;
            rise_pulse <= gate_lvl & ~sig_out;
            fall_pulse <= ~gate_lvl & sig_out;
        end
    end

    // Built only from flop outputs, so it cannot glitch between edges.
    assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_sync_filter_bank.sv
// tb_sync_filter_bank
// -----------------------------------------------------------------------------
// Bench for sync_filter_bank with WIDTH=4, STAGES=2, FILT_CNT=3. It runs the
// directed scenarios and then randomized traffic. Every output is compared
// each cycle against a reference model. The model keeps a history of captured
// inputs. A channel's filtered level takes a new value once the last FILT_CNT
// synchronized samples all agree on it. It follows the
// SYNC_FILTER_BANK_GLITCH_FILTER_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_sync_filter_bank;

    localparam int WIDTH    = 4;
    localparam int STAGES   = 2;
    localparam int FILT_CNT = 3;
`ifdef SYNC_FILTER_BANK_GLITCH_FILTER_EN
    localparam int LATENCY  = STAGES + FILT_CNT;
`else
    localparam int LATENCY  = STAGES;
`endif

    logic             d_clk;
    logic             d_rst_n;
    logic [WIDTH-1:0] sig_in;
    logic [WIDTH-1:0] sig_en;
    logic [WIDTH-1:0] sig_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             any_change;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference model state. cap_hist holds the sig_in value captured at each
    // edge, oldest first. Zeros stand in for the cleared synchronizer.
    logic [WIDTH-1:0] cap_hist [$];
    logic [WIDTH-1:0] m_filt;
    logic [WIDTH-1:0] m_out;
    logic [WIDTH-1:0] m_rise;
    logic [WIDTH-1:0] m_fall;

    sync_filter_bank #(
        .WIDTH    (WIDTH),
        .STAGES   (STAGES),
        .FILT_CNT (FILT_CNT)
    ) dut (
        .d_clk      (d_clk),
        .d_rst_n    (d_rst_n),
        .sig_in     (sig_in),
        .sig_en     (sig_en),
        .sig_out    (sig_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    initial d_clk = 1'b0;
    always #5 d_clk = ~d_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_cnt++;
        if (observed !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        cap_hist = {};
        for (int i = 0; i < STAGES + FILT_CNT; i++) begin
            cap_hist.push_back('0);
        end
        m_filt = '0;
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
    endtask

    // One rising edge of the model. The sample the synchronizer presents at
    // edge t is the value captured at edge t-STAGES.
    task automatic modelStep(input logic [WIDTH-1:0] in_v,
                             input logic [WIDTH-1:0] en_v);
        logic [WIDTH-1:0] level;
        logic [WIDTH-1:0] gated;
        logic [WIDTH-1:0] all_one;
        logic [WIDTH-1:0] all_zero;
        int n;
        n = cap_hist.size();
`ifdef SYNC_FILTER_BANK_GLITCH_FILTER_EN
        level = m_filt;
`else
        level = cap_hist[n - STAGES];
`endif
        gated  = level & en_v;
        m_rise = gated & ~m_out;
        m_fall = ~gated & m_out;
        m_out  = gated;
        // The filtered level moves once the last FILT_CNT samples agree.
        all_one  = '1;
        all_zero = '1;
        for (int k = n - STAGES - FILT_CNT + 1; k <= n - STAGES; k++) begin
            all_one  = all_one & cap_hist[k];
            all_zero = all_zero & ~cap_hist[k];
        end
        m_filt = (m_filt | all_one) & ~all_zero;
        cap_hist.push_back(in_v);
        void'(cap_hist.pop_front());
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model on
    // the rising edge, then compare every output shortly after it.
    task automatic applyStimulus(input logic [WIDTH-1:0] in_v,
                                 input logic [WIDTH-1:0] en_v,
                                 input logic             rst_n_v);
        @(negedge d_clk);
        sig_in = in_v;
        sig_en = en_v;
        if (!rst_n_v && d_rst_n) begin
            d_rst_n = 1'b0;
            #1;
            modelReset();
            checkOutput("async_clear", {19'd0, sig_out, rise_pulse, fall_pulse, any_change}, 32'd0);
        end
        d_rst_n = rst_n_v;
        @(posedge d_clk);
        if (!rst_n_v) modelReset();
        else          modelStep(in_v, en_v);
        #1;
        checkOutput("sig_out",    {28'd0, sig_out},    {28'd0, m_out});
        checkOutput("rise_pulse", {28'd0, rise_pulse}, {28'd0, m_rise});
        checkOutput("fall_pulse", {28'd0, fall_pulse}, {28'd0, m_fall});
        checkOutput("any_change", {31'd0, any_change}, {31'd0, |(m_rise | m_fall)});
    endtask

    initial begin
        logic [WIDTH-1:0] rnd_in;
        logic [WIDTH-1:0] rnd_en;
        int seen;

        sig_in  = '0;
        sig_en  = '1;
        d_rst_n = 1'b0;
        modelReset();

        // Reset held with all inputs high.
        for (int i = 0; i < 10; i++) applyStimulus(4'hF, 4'hF, 1'b0);
        applyStimulus(4'h0, 4'hF, 1'b1);
        applyStimulus(4'h0, 4'hF, 1'b1);

        // Latency of channel 0, counted from the capture edge.
        applyStimulus(4'h1, 4'hF, 1'b1);
        seen = 0;
        for (int j = 1; j <= 20; j++) begin
            applyStimulus(4'h1, 4'hF, 1'b1);
            if (sig_out[0]) begin
                seen = j;
                break;
            end
        end
        checkOutput("rise_latency", seen, LATENCY);
        for (int i = 0; i < 4; i++) applyStimulus(4'h1, 4'hF, 1'b1);
        applyStimulus(4'h0, 4'hF, 1'b1);
        seen = 0;
        for (int j = 1; j <= 20; j++) begin
            applyStimulus(4'h0, 4'hF, 1'b1);
            if (!sig_out[0]) begin
                seen = j;
                break;
            end
        end
        checkOutput("fall_latency", seen, LATENCY);
        for (int i = 0; i < 4; i++) applyStimulus(4'h0, 4'hF, 1'b1);

        // Two-cycle glitch on channel 1, then a three-cycle pulse.
        applyStimulus(4'h2, 4'hF, 1'b1);
        applyStimulus(4'h2, 4'hF, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(4'h0, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(4'h2, 4'hF, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(4'h0, 4'hF, 1'b1);

        // Enable gating on channel 2 while its level is steady high.
        for (int i = 0; i < 8; i++) applyStimulus(4'h4, 4'hF, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(4'h4, 4'hB, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(4'h4, 4'hF, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(4'h0, 4'hF, 1'b1);

        // Two channels rising together.
        for (int i = 0; i < 10; i++) applyStimulus(4'hA, 4'hF, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(4'h0, 4'hF, 1'b1);

        // Reset in the middle of a channel 3 filter run, then a fresh rise.
        for (int i = 0; i < STAGES + 2; i++) applyStimulus(4'h8, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(4'h8, 4'hF, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(4'h8, 4'hF, 1'b1);

        // Randomized traffic: sticky inputs so filtered runs appear, rare
        // enable drops and an occasional reset.
        rnd_in = 4'h8;
        rnd_en = 4'hF;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < WIDTH; c++) begin
                if ($urandom_range(3) == 0) rnd_in[c] = ~rnd_in[c];
                if ($urandom_range(15) == 0) rnd_en[c] = ~rnd_en[c];
            end
            applyStimulus(rnd_in, rnd_en, ($urandom_range(99) != 0));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
